// File: rtl/cgra_clk_gate_ctrl.sv
// cgra_clk_gate_ctrl
// Idle-driven clock gating controller for the CGRA. Watches kernel activity,
// drops the registered clock enable after a run of idle cycles, and brings the
// clock back (with a fixed warm-up) when a request or software override shows
// up. Kernel-start requests are only passed through while the clock is fully
// running.
//
// Optional build macro: CGRA_CLK_GATE_STATS_EN
//   defined   -> gated_cycles_o counts cycles spent gated (saturating)
//   undefined -> gated_cycles_o is tied to zero, no counter flops
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | clock enabled, requests forwarded, idle run being counted
// OFF   | clock gated, waiting for a request or force_on_i
// WAKE  | clock enabled again, settling for WAKE_CYCLES cycles

module cgra_clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        busy_i,
    input  logic        force_on_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        clk_en_o,
    output logic        gated_o,
    output logic [31:0] gated_cycles_o
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_OFF  = 2'd1;
    localparam logic [1:0] S_WAKE = 2'd2;

    localparam logic [7:0] IDLE_TC = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_TC = 8'(WAKE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_clk_en;
    logic       r_gated;
    logic       w_idle;
    logic       w_run;

    assign w_idle = ~busy_i & ~req_valid_i & ~force_on_i;
    assign w_run  = (r_state == S_RUN);

    // Next-state and shared idle/wake counter; the terminal count always
    // leaves the state, so the 8-bit counter never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!w_idle) begin
                    w_cnt_nxt = 8'd0;
                end else if (r_cnt == IDLE_TC) begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_OFF: begin
                w_cnt_nxt = 8'd0;
                if (req_valid_i || force_on_i) begin
                    w_state_nxt = S_WAKE;
                end
            end
            S_WAKE: begin
                if (r_cnt == WAKE_TC) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // State, counter and the registered enable/status outputs; the enable
    // comes up in reset so the gated domain sees its reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_RUN;
            r_cnt    <= 8'd0;
            r_clk_en <= 1'b1;
            r_gated  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clk_en <= (w_state_nxt != S_OFF);
            r_gated  <= (w_state_nxt == S_OFF);
        end
    end

    assign clk_en_o    = r_clk_en;
    assign gated_o     = r_gated;
    assign req_valid_o = req_valid_i & w_run;
    assign req_ready_o = req_ready_i & w_run;

`ifdef CGRA_CLK_GATE_STATS_EN
    logic [31:0] r_gated_cycles;

    // Saturating count of cycles spent in OFF; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gated_cycles <= 32'd0;
        end else if ((r_state == S_OFF) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
            r_gated_cycles <= r_gated_cycles + 32'd1;
        end
    end

    assign gated_cycles_o = r_gated_cycles;
`else
    assign gated_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_cgra_clk_gate_ctrl.sv
// Testbench for cgra_clk_gate_ctrl: directed scenarios followed by random
// traffic, checked through a scoreboard queue against a timeline model.
module tb_cgra_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 16;
    localparam int WAKE_CYCLES = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        busy_i;
    logic        force_on_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        clk_en_o;
    logic        gated_o;
    logic [31:0] gated_cycles_o;

    cgra_clk_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .busy_i        (busy_i),
        .force_on_i    (force_on_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .clk_en_o      (clk_en_o),
        .gated_o       (gated_o),
        .gated_cycles_o(gated_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          en;
        bit          gated;
        bit          rvo;
        bit          rro;
        logic [31:0] gc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Timeline model: gated flag, the cycle at which the clock is fully
    // running again, and the length of the current idle streak.
    bit          m_gated  = 0;
    int          m_run_at = 0;
    int          m_streak = 0;
    int          m_cyc    = 0;
    longint      m_stats  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit f, input bit v, input bit rd);
        exp_t e;
        bit   running;
        @(posedge clk_i);
        #1;
        rst_i       = r;
        busy_i      = b;
        force_on_i  = f;
        req_valid_i = v;
        req_ready_i = rd;
        running = !m_gated && (m_cyc >= m_run_at);
        e.en    = !m_gated;
        e.gated = m_gated;
        e.rvo   = v && running;
        e.rro   = rd && running;
`ifdef CGRA_CLK_GATE_STATS_EN
        e.gc    = (m_stats > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stats);
`else
        e.gc    = 32'd0;
`endif
        e.cyc   = m_cyc;
        q.push_back(e);
        if (r) begin
            m_gated  = 0;
            m_run_at = 0;
            m_streak = 0;
            m_stats  = 0;
        end else if (m_gated) begin
            m_stats++;
            if (v || f) begin
                m_gated  = 0;
                m_run_at = m_cyc + 1 + WAKE_CYCLES;
            end
        end else if (running) begin
            if (!b && !v && !f) m_streak++;
            else                m_streak = 0;
            if (m_streak == IDLE_CYCLES) begin
                m_gated  = 1;
                m_streak = 0;
            end
        end
        m_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the
    // oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("clk_en", 32'(clk_en_o), 32'(e.en), e.cyc);
            chk("gated", 32'(gated_o), 32'(e.gated), e.cyc);
            chk("req_valid_o", 32'(req_valid_o), 32'(e.rvo), e.cyc);
            chk("req_ready_o", 32'(req_ready_o), 32'(e.rro), e.cyc);
            chk("gated_cycles", gated_cycles_o, e.gc, e.cyc);
        end
    end

    initial begin
        int act;
        rst_i = 1; busy_i = 0; force_on_i = 0; req_valid_i = 0; req_ready_i = 0;
        repeat (2) @(posedge clk_i);

        // Power-on idle: gate after IDLE_CYCLES idle cycles.
        idle(20);
        // Held request in OFF with ready high.
        repeat (5) step(0, 0, 0, 1, 1);
        // Idle run broken by a single busy cycle.
        idle(15);
        step(0, 1, 0, 0, 0);
        idle(20);
        // Long software override keeps the clock on.
        repeat (100) step(0, 0, 1, 0, 0);
        // Override pulse in OFF wakes the clock.
        idle(20);
        step(0, 0, 1, 0, 0);
        idle(5);
        // Reset during WAKE, pending request forwarded at once.
        idle(14);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        // Long OFF residency for the statistics counter.
        idle(16 + 41);
        step(0, 0, 0, 0, 0);

        // Random traffic in segments of quiet and active behaviour.
        for (int s = 0; s < 40; s++) begin
            act = $urandom_range(0, 2);
            for (int i = 0; i < 50; i++) begin
                bit b, f, v, rd, r;
                if (act == 0) begin
                    b = ($urandom_range(0, 59) == 0);
                    f = ($urandom_range(0, 79) == 0);
                    v = ($urandom_range(0, 39) == 0);
                end else begin
                    b = ($urandom_range(0, 2) == 0);
                    f = ($urandom_range(0, 19) == 0);
                    v = ($urandom_range(0, 4) == 0);
                end
                rd = $urandom_range(0, 1);
                r  = ($urandom_range(0, 249) == 0);
                step(r, b, f, v, rd);
            end
        end

        step(0, 0, 0, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("queue_drain", 32'(q.size()), 32'd0, m_cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cgra_clk_gate_ctrl.md
CGRA_CLK_GATE_CTRL -- requirements
Module: cgra_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 16: consecutive idle cycles in RUN before gating; legal range 1..255.
REQ-002 SHALL have parameter WAKE_CYCLES, default 2: enabled-clock cycles in WAKE before requests pass; legal range 1..255.
REQ-003 SHALL have port clk_i  input  1: free-running clock, not gated.
REQ-004 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port busy_i  input  1: CGRA reports a kernel in flight.
REQ-006 SHALL have port force_on_i  input  1: software override that keeps the clock enabled.
REQ-007 SHALL have port req_valid_i  input  1: upstream kernel-start request valid.
REQ-008 SHALL have port req_ready_o  output  1: upstream request accepted.
REQ-009 SHALL have port req_valid_o  output  1: request forwarded to the CGRA.
REQ-010 SHALL have port req_ready_i  input  1: CGRA accepts the forwarded request.
REQ-011 SHALL have port clk_en_o  output  1: registered enable driving en_i of cgra_clock_gate.
REQ-012 SHALL have port gated_o  output  1: status, high while in OFF.
REQ-013 SHALL have port gated_cycles_o  output  32: statistics counter (see Configuration).

Function
REQ-014 SHALL implement FSM states RUN, OFF, WAKE; all outputs SHALL derive from registered state/counter only, except the request handshake.
REQ-015 RUN: clk_en_o=1; idle counter increments each cycle where busy_i=0, req_valid_i=0 and force_on_i=0; otherwise it clears to 0.
REQ-016 RUN: when the idle counter equals IDLE_CYCLES-1 and the cycle is idle, the next state SHALL be OFF and the counter SHALL clear; clk_en_o falls exactly IDLE_CYCLES cycles after the first idle cycle.
REQ-017 OFF: clk_en_o=0 and gated_o=1; req_valid_i=1 or force_on_i=1 SHALL move to WAKE next cycle with the counter cleared.
REQ-018 WAKE: clk_en_o=1; the counter increments every cycle; at WAKE_CYCLES-1 the next state SHALL be RUN; requests are not forwarded during WAKE.
REQ-019 Handshake: req_valid_o = req_valid_i AND (state==RUN); req_ready_o = req_ready_i AND (state==RUN); combinational pass-through, zero latency.
REQ-020 A request held with req_valid_i=1 in OFF SHALL be forwarded in the first RUN cycle, WAKE_CYCLES+1 cycles after its assertion; upstream SHALL hold valid until ready.
REQ-021 Transition RUN->OFF SHALL be suppressed in any cycle where req_valid_i, busy_i or force_on_i is high, including the terminal-count cycle.
REQ-022 busy_i is ignored in OFF and WAKE; force_on_i in WAKE has no effect on wake timing.
REQ-023 Counter width SHALL be 8 bits; it never wraps because the terminal count always causes a state change.

Reset
REQ-024 On rst_i=1 at a clk_i edge: state=RUN, counter=0, clk_en_o=1, gated_o=0, gated_cycles_o=0.
REQ-025 Reset mid-WAKE or mid-OFF SHALL return to RUN in the next cycle; a pending request is then forwarded immediately.
REQ-026 clk_en_o SHALL be high during reset so the gated CGRA domain receives its reset.

Configuration
REQ-027 Macro CGRA_CLK_GATE_STATS_EN defined: gated_cycles_o increments once per cycle in OFF, saturates at 0xFFFFFFFF, and clears only on reset.
REQ-028 Macro CGRA_CLK_GATE_STATS_EN undefined: no counter flops; gated_cycles_o is tied to 0; port list is unchanged.

Verification
REQ-029 Reset, then hold busy_i=0 and req_valid_i=0 with IDLE_CYCLES=16 -> clk_en_o=1 for 16 cycles, 0 from cycle 17, gated_o=1.
REQ-030 In OFF, pulse req_valid_i=1 and hold it with req_ready_i=1, WAKE_CYCLES=2 -> clk_en_o=1 next cycle; req_valid_o=1 and req_ready_o=1 exactly 3 cycles after assertion.
REQ-031 Idle for 15 cycles, then busy_i=1 for 1 cycle, then idle -> no gating until 16 further idle cycles.
REQ-032 force_on_i=1 for 100 cycles with busy_i=0 -> clk_en_o stays 1; in OFF, force_on_i=1 triggers WAKE then RUN.
REQ-033 Assert rst_i during WAKE -> RUN next cycle, clk_en_o=1, counter 0.
REQ-034 With STATS_EN defined, remain in OFF for 40 cycles -> gated_cycles_o=40; with it undefined -> gated_cycles_o=0.
